switch_debounce: RTL

//  Conditions raw asynchronous switch/button inputs before they reach the D inputs of downstream flip-flops.
//  Per channel: 2-FF synchroniser, stability counter, debounced level output and one-cycle rise/fall pulses.

---
 rtl/debounce_pkg.sv | 12 +
 rtl/debounce_channel.sv | 66 ++++++
 rtl/switch_debounce.sv | 32 +++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared constants for the switch debouncer: synchroniser depth and
// stability-counter sizing.
package debounce_pkg;

  localparam int SYNC_STAGES = 2;

  // Enough bits to hold a count up to and including n.
  function automatic int cnt_width(int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: synchroniser, stability counter, level output and
// registered one-cycle rise/fall pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic CLK,
  input  logic Reset,
  input  logic d_raw,
  output logic q,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   q_q, q_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s_sync;

  // Only the last synchroniser stage is allowed to influence the debounce.
  assign s_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_raw};
    cnt_d  = '0;
    q_d    = q_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s_sync != q_q) begin
      if (cnt_q == CNT_LAST) begin
        q_d    = s_sync;
        rise_d = s_sync;
        fall_d = ~s_sync;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      q_q    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q    = q_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/switch_debounce.sv
// Multi-channel switch debouncer between the board pins and the registered
// datapath; every channel is an independent debounce_channel.
module switch_debounce
  import debounce_pkg::*;
#(
  parameter int WIDTH         = 1,
  parameter int STABLE_CYCLES = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] D_raw,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      debounce_channel #(
        .STABLE_CYCLES(STABLE_CYCLES)
      ) u_chan (
        .CLK  (CLK),
        .Reset(Reset),
        .d_raw(D_raw[gi]),
        .q    (Q[gi]),
        .rise (rise[gi]),
        .fall (fall[gi])
      );
    end
  endgenerate

endmodule
